// File: rtl/if_prefetch_queue.sv
// Instruction-fetch prefetch queue: issues sequential reads to a 1-cycle-latency instruction
// memory and buffers returned words with their PC+4, presented first-word-fall-through to IF/ID.
module if_prefetch_queue #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        id_stall,
   output logic        out_valid,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc_incr
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

   logic [31:0]      fetch_pc;
   logic [31:0]      tag_pc;
   logic             inflight;
   logic [PTR_W:0]   count;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;

   logic [31:0] instr_q   [DEPTH];
   logic [31:0] pc_incr_q [DEPTH];

   logic           push;
   logic           pop;
   logic [PTR_W:0] occupancy;

   // Slots already promised: buffered words plus the one read still in flight.
   assign occupancy = count + {{PTR_W{1'b0}}, inflight};
   assign imem_addr = fetch_pc;

   always_comb begin
      // NOTE: every output of this block gets a default first so no path infers a latch.
      imem_req    = 1'b0;
      out_valid   = 1'b0;
      out_instr   = 32'h0;
      out_pc_incr = 32'h0;
      push        = 1'b0;
      pop         = 1'b0;
      if (rst) begin
         imem_req  = !redirect_valid && (occupancy < DEPTH_C);
         out_valid = (count != '0) && !redirect_valid;
         push      = inflight && !redirect_valid;
         pop       = out_valid && !id_stall;
         if (out_valid) begin
            out_instr   = instr_q[rd_ptr];
            out_pc_incr = pc_incr_q[rd_ptr];
         end
      end
   end

   // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst) begin
         fetch_pc <= RESET_PC;
         tag_pc   <= RESET_PC;
         inflight <= 1'b0;
         count    <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
      end else if (redirect_valid) begin
         fetch_pc <= redirect_pc & ~32'h3;
         inflight <= 1'b0;
         count    <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
      end else begin
         inflight <= imem_req;
         if (imem_req) begin
            tag_pc   <= fetch_pc;
            fetch_pc <= fetch_pc + 32'd4;
         end
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + (PTR_W + 1)'(1);
            2'b01:   count <= count - (PTR_W + 1)'(1);
            default: count <= count;
         endcase
      end
   end

   // NOTE: queue storage is not reset; count gates every read, so stale contents are never seen.
   always_ff @(posedge clk) begin
      if (push) begin
         instr_q[wr_ptr]   <= imem_rdata;
         pc_incr_q[wr_ptr] <= tag_pc + 32'd4;
      end
   end

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Self-checking bench for if_prefetch_queue: a transaction-level fetch model feeds a scoreboard
// of expected {instr, pc+4} pairs that is compared against the DUT head every cycle.
module tb_if_prefetch_queue;

   localparam int unsigned DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata = 32'h0;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        id_stall;
   logic        out_valid;
   logic [31:0] out_instr;
   logic [31:0] out_pc_incr;

   int checks   = 0;
   int failures = 0;

   // Model state
   logic [63:0] sb[$];
   logic [31:0] m_pc;
   logic [31:0] m_tag;
   logic        m_inflight;

   if_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .id_stall       (id_stall),
      .out_valid      (out_valid),
      .out_instr      (out_instr),
      .out_pc_incr    (out_pc_incr)
   );

   always #5 clk = ~clk;

   // Instruction memory: returns the requested address as data one cycle later.
   always @(posedge clk) imem_rdata <= imem_req ? imem_addr : 32'hDEAD_BEEF;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      sb.delete();
      m_pc       = RESET_PC;
      m_tag      = RESET_PC;
      m_inflight = 1'b0;
   endtask

   // One clock cycle: drive inputs, compare outputs mid-cycle, advance the model to the edge.
   task automatic step(input logic r, input logic rv, input logic [31:0] rp, input logic st);
      logic exp_req;
      logic exp_valid;
      rst            = r;
      redirect_valid = rv;
      redirect_pc    = rp;
      id_stall       = st;
      @(negedge clk);
      exp_req   = r && !rv && ((sb.size() + int'(m_inflight)) < DEPTH);
      exp_valid = r && !rv && (sb.size() != 0);
      check("imem_req", {31'h0, imem_req}, {31'h0, exp_req});
      if (exp_req) check("imem_addr", imem_addr, m_pc);
      check("out_valid", {31'h0, out_valid}, {31'h0, exp_valid});
      if (exp_valid) begin
         check("out_instr", out_instr, sb[0][63:32]);
         check("out_pc_incr", out_pc_incr, sb[0][31:0]);
      end else begin
         check("out_instr_nop", out_instr, 32'h0);
         check("out_pc_incr_nop", out_pc_incr, 32'h0);
      end
      if (!r) begin
         model_reset();
      end else if (rv) begin
         sb.delete();
         m_inflight = 1'b0;
         m_pc       = rp & ~32'h3;
      end else begin
         if (exp_valid && !st) void'(sb.pop_front());
         if (m_inflight) sb.push_back({m_tag, m_tag + 32'd4});
         m_inflight = exp_req;
         if (exp_req) begin
            m_tag = m_pc;
            m_pc  = m_pc + 32'd4;
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; id_stall = 1'b0;
      model_reset();
      @(posedge clk);
      #1;

      // Reset state
      repeat (3) step(1'b0, 1'b0, 32'h0, 1'b0);

      // Fill with IF/ID stalled
      repeat (8) step(1'b1, 1'b0, 32'h0, 1'b1);
      check("fill_req_idle", {31'h0, imem_req}, 32'h0);
      check("fill_head_pc", out_pc_incr, 32'h4);
      check("fill_head_instr", out_instr, 32'h0);

      // Stream
      repeat (12) step(1'b1, 1'b0, 32'h0, 1'b0);

      // Redirect with a read in flight
      step(1'b1, 1'b1, 32'h43, 1'b0);
      check("redir_addr", imem_addr, 32'h40);
      repeat (8) step(1'b1, 1'b0, 32'h0, 1'b0);

      // Full queue, stall toggling
      repeat (8) step(1'b1, 1'b0, 32'h0, 1'b1);
      for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 32'h0, i[0]);
      repeat (6) step(1'b1, 1'b0, 32'h0, 1'b0);

      // Back-to-back redirects: the last one wins
      step(1'b1, 1'b1, 32'h100, 1'b1);
      step(1'b1, 1'b1, 32'h202, 1'b0);
      check("redir_last_wins", imem_addr, 32'h200);
      repeat (6) step(1'b1, 1'b0, 32'h0, 1'b0);

      // Address wrap
      step(1'b1, 1'b1, 32'hFFFF_FFF8, 1'b0);
      check("wrap_addr", imem_addr, 32'hFFFF_FFF8);
      repeat (8) step(1'b1, 1'b0, 32'h0, 1'b0);

      // Reset mid-run: three buffered words plus one in flight
      step(1'b1, 1'b1, 32'h500, 1'b1);
      repeat (4) step(1'b1, 1'b0, 32'h0, 1'b1);
      step(1'b0, 1'b0, 32'h0, 1'b1);
      check("rst_mid_valid", {31'h0, out_valid}, 32'h0);
      check("rst_mid_req", {31'h0, imem_req}, 32'h0);
      step(1'b1, 1'b0, 32'h0, 1'b0);
      check("rst_restart_addr", imem_addr, RESET_PC + 32'd4);
      repeat (8) step(1'b1, 1'b0, 32'h0, 1'b0);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         logic r;
         logic rv;
         logic st;
         r  = ($urandom_range(0, 99) != 0);
         rv = ($urandom_range(0, 15) == 0);
         st = ($urandom_range(0, 2) == 0);
         step(r, rv, $urandom, st);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
